// File: rtl/grayscale_pipe_if.sv
// grayscale_pipe_if: pixel stream bundle between the pixel input stage, grayscale_pipe and the edge filters
// Signals:
//    I_ENABLE, I_MODE, I_PIXEL, I_LAST, I_VALID / O_READY : input pixel stream and intake gate
//    O_PIXEL, O_VALID / I_READY                          : luma output stream, {Y,Y,Y}
//    O_COUNT, O_DONE                                     : per-frame output count and frame-end pulse
// Modports: master = upstream/downstream side, slave = converter side.
interface grayscale_pipe_if #(
   parameter int P_CHANNEL_DEPTH = 8,
   parameter int P_COUNT_WIDTH   = 20
);
   logic                         I_ENABLE;
   logic [1:0]                   I_MODE;
   logic [3*P_CHANNEL_DEPTH-1:0] I_PIXEL;
   logic                         I_LAST;
   logic                         I_VALID;
   logic                         O_READY;
   logic [3*P_CHANNEL_DEPTH-1:0] O_PIXEL;
   logic                         O_VALID;
   logic                         I_READY;
   logic [P_COUNT_WIDTH-1:0]     O_COUNT;
   logic                         O_DONE;
   modport master (
      output I_ENABLE, I_MODE, I_PIXEL, I_LAST, I_VALID, I_READY,
      input  O_READY, O_PIXEL, O_VALID, O_COUNT, O_DONE
   );
   modport slave (
      input  I_ENABLE, I_MODE, I_PIXEL, I_LAST, I_VALID, I_READY,
      output O_READY, O_PIXEL, O_VALID, O_COUNT, O_DONE
   );
endinterface

// File: rtl/grayscale_pipe.sv
// grayscale_pipe: 3-stage RGB-to-luma converter with per-pixel mode, valid/ready flow control and frame counting
// Ports:
//    I_CLK   : clock, rising edge
//    I_RESET : asynchronous active-high reset
//    bus     : slave side of grayscale_pipe_if (input stream, luma output stream, O_COUNT/O_DONE status)
// Stages: S1 per-channel products (or max), S2 product sum, S3 round/saturate/replicate.
module grayscale_pipe #(
   parameter int P_CHANNEL_DEPTH = 8,
   parameter int P_COUNT_WIDTH   = 20
) (
   input logic             I_CLK,
   input logic             I_RESET,
   grayscale_pipe_if.slave bus
);
   localparam int C = P_CHANNEL_DEPTH;
   localparam logic [1:0] MODE_601 = 2'b00;
   localparam logic [1:0] MODE_709 = 2'b01;
   localparam logic [1:0] MODE_AVG = 2'b10;
   localparam logic [1:0] MODE_MAX = 2'b11;

   logic             advance, in_xfer, out_xfer;
   logic [C-1:0]     r, g, b, rgb_max, y_sat;
   logic [7:0]       k_r, k_g, k_b;
   logic [C+1:0]     y_round;

   logic             s1_valid_d, s1_valid_q, s1_last_d, s1_last_q, s1_is_max_d, s1_is_max_q;
   logic [C+7:0]     s1_pr_d, s1_pr_q, s1_pg_d, s1_pg_q, s1_pb_d, s1_pb_q;
   logic [C-1:0]     s1_max_d, s1_max_q;
   logic             s2_valid_d, s2_valid_q, s2_last_d, s2_last_q, s2_is_max_d, s2_is_max_q;
   logic [C+9:0]     s2_sum_d, s2_sum_q;
   logic [C-1:0]     s2_max_d, s2_max_q;
   logic             s3_valid_d, s3_valid_q, s3_last_d, s3_last_q;
   logic [C-1:0]     s3_y_d, s3_y_q;
   logic [P_COUNT_WIDTH-1:0] count_d, count_q;
   logic             done_d, done_q;

   // Whole pipeline moves as one; a bubble in S3 never blocks it.
   assign advance     = !s3_valid_q || bus.I_READY;
   assign bus.O_READY = bus.I_ENABLE && advance && !I_RESET;
   assign in_xfer     = bus.I_VALID && bus.O_READY;
   assign out_xfer    = s3_valid_q && bus.I_READY;

   assign r = bus.I_PIXEL[3*C-1:2*C];
   assign g = bus.I_PIXEL[2*C-1:C];
   assign b = bus.I_PIXEL[C-1:0];

   always_comb begin
      k_r     = bus.I_MODE == MODE_601 ? 8'd77  : bus.I_MODE == MODE_709 ? 8'd54  : bus.I_MODE == MODE_AVG ? 8'd85 : 8'd0;
      k_g     = bus.I_MODE == MODE_601 ? 8'd150 : bus.I_MODE == MODE_709 ? 8'd183 : bus.I_MODE == MODE_AVG ? 8'd86 : 8'd0;
      k_b     = bus.I_MODE == MODE_601 ? 8'd29  : bus.I_MODE == MODE_709 ? 8'd19  : bus.I_MODE == MODE_AVG ? 8'd85 : 8'd0;
      rgb_max = (r > g) ? ((r > b) ? r : b) : ((g > b) ? g : b);
      // Rounding add then >>8 keeps C+2 bits; anything above C bits saturates.
      y_round = (C+2)'((s2_sum_q + (C+10)'(128)) >> 8);
      y_sat   = |y_round[C+1:C] ? {C{1'b1}} : y_round[C-1:0];
   end

   always_comb begin
      s1_valid_d  = advance ? in_xfer : s1_valid_q;
      s1_last_d   = advance ? bus.I_LAST : s1_last_q;
      s1_is_max_d = advance ? bus.I_MODE == MODE_MAX : s1_is_max_q;
      s1_pr_d     = advance ? (C+8)'(r) * (C+8)'(k_r) : s1_pr_q;
      s1_pg_d     = advance ? (C+8)'(g) * (C+8)'(k_g) : s1_pg_q;
      s1_pb_d     = advance ? (C+8)'(b) * (C+8)'(k_b) : s1_pb_q;
      s1_max_d    = advance ? rgb_max : s1_max_q;
      s2_valid_d  = advance ? s1_valid_q : s2_valid_q;
      s2_last_d   = advance ? s1_last_q : s2_last_q;
      s2_is_max_d = advance ? s1_is_max_q : s2_is_max_q;
      s2_sum_d    = advance ? (C+10)'(s1_pr_q) + (C+10)'(s1_pg_q) + (C+10)'(s1_pb_q) : s2_sum_q;
      s2_max_d    = advance ? s1_max_q : s2_max_q;
      s3_valid_d  = advance ? s2_valid_q : s3_valid_q;
      s3_last_d   = advance ? s2_last_q : s3_last_q;
      s3_y_d      = advance ? (s2_is_max_q ? s2_max_q : y_sat) : s3_y_q;
      count_d     = out_xfer ? (s3_last_q ? '0 : count_q + 1'b1) : count_q;
      done_d      = out_xfer && s3_last_q;
   end

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_is_max_q <= 1'b0;
         s1_pr_q     <= '0;
         s1_pg_q     <= '0;
         s1_pb_q     <= '0;
         s1_max_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         s2_is_max_q <= 1'b0;
         s2_sum_q    <= '0;
         s2_max_q    <= '0;
         s3_valid_q  <= 1'b0;
         s3_last_q   <= 1'b0;
         s3_y_q      <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         s1_is_max_q <= s1_is_max_d;
         s1_pr_q     <= s1_pr_d;
         s1_pg_q     <= s1_pg_d;
         s1_pb_q     <= s1_pb_d;
         s1_max_q    <= s1_max_d;
         s2_valid_q  <= s2_valid_d;
         s2_last_q   <= s2_last_d;
         s2_is_max_q <= s2_is_max_d;
         s2_sum_q    <= s2_sum_d;
         s2_max_q    <= s2_max_d;
         s3_valid_q  <= s3_valid_d;
         s3_last_q   <= s3_last_d;
         s3_y_q      <= s3_y_d;
         count_q     <= count_d;
         done_q      <= done_d;
      end
   end

   assign bus.O_PIXEL = {3{s3_y_q}};
   assign bus.O_VALID = s3_valid_q;
   assign bus.O_COUNT = count_q;
   assign bus.O_DONE  = done_q;
endmodule

// File: tb/tb_grayscale_pipe.sv
// tb_grayscale_pipe: directed self-checking bench for grayscale_pipe (C=8, 20-bit counter)
module tb_grayscale_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   grayscale_pipe_if #(.P_CHANNEL_DEPTH(8), .P_COUNT_WIDTH(20)) bus ();
   grayscale_pipe #(.P_CHANNEL_DEPTH(8), .P_COUNT_WIDTH(20)) dut (
      .I_CLK  (clk),
      .I_RESET(rst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic l);
      bus.I_VALID = v;
      bus.I_MODE  = m;
      bus.I_PIXEL = {r, g, b};
      bus.I_LAST  = l;
   endtask

   task automatic test_reset;
      bus.I_ENABLE = 1'b1;
      bus.I_READY  = 1'b1;
      drive(1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      tick;
      tick;
      checks++;
      if (bus.O_VALID !== 1'b0 || bus.O_PIXEL !== 24'h0) begin
         errors++;
         $display("FAIL reset_out: valid=%b pixel=%h want 0/000000", bus.O_VALID, bus.O_PIXEL);
      end
      checks++;
      if (bus.O_COUNT !== 20'd0 || bus.O_DONE !== 1'b0) begin
         errors++;
         $display("FAIL reset_count: count=%0d done=%b want 0/0", bus.O_COUNT, bus.O_DONE);
      end
      checks++;
      if (bus.O_READY !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b want 0", bus.O_READY);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.O_READY !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b want 1", bus.O_READY);
      end
   endtask

   // Ten pixels back to back, all modes interleaved, last on pixel 9.
   task automatic test_modes;
      int md[10] = '{0, 0, 0, 1, 2, 3, 0, 1, 3, 2};
      int rr[10] = '{255, 255, 100, 0, 30, 30, 0, 255, 7, 255};
      int gg[10] = '{0, 255, 100, 255, 60, 60, 0, 255, 200, 255};
      int bb[10] = '{0, 255, 100, 0, 90, 90, 255, 255, 3, 255};
      int yy[10] = '{77, 255, 100, 182, 60, 90, 29, 255, 200, 255};
      logic [7:0] y;
      for (int t = 0; t < 12; t++) begin
         if (t < 10) drive(1'b1, 2'(md[t]), 8'(rr[t]), 8'(gg[t]), 8'(bb[t]), t == 9);
         else drive(1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
         #1;
         checks++;
         if (bus.O_READY !== 1'b1) begin
            errors++;
            $display("FAIL modes_ready t=%0d: got %b want 1", t, bus.O_READY);
         end
         tick;
         if (t < 2) begin
            checks++;
            if (bus.O_VALID !== 1'b0) begin
               errors++;
               $display("FAIL modes_latency t=%0d: valid=%b want 0", t, bus.O_VALID);
            end
         end else begin
            y = 8'(yy[t-2]);
            checks++;
            if (bus.O_VALID !== 1'b1 || bus.O_PIXEL !== {y, y, y}) begin
               errors++;
               $display("FAIL modes_pixel %0d: valid=%b pixel=%h want 1/%h", t - 2, bus.O_VALID, bus.O_PIXEL, {y, y, y});
            end
            checks++;
            if (bus.O_COUNT !== 20'(t - 2) || bus.O_DONE !== 1'b0) begin
               errors++;
               $display("FAIL modes_count %0d: count=%0d done=%b want %0d/0", t - 2, bus.O_COUNT, bus.O_DONE, t - 2);
            end
         end
      end
      tick;
      checks++;
      if (bus.O_VALID !== 1'b0 || bus.O_COUNT !== 20'd0 || bus.O_DONE !== 1'b1) begin
         errors++;
         $display("FAIL modes_end: valid=%b count=%0d done=%b want 0/0/1", bus.O_VALID, bus.O_COUNT, bus.O_DONE);
      end
      tick;
      checks++;
      if (bus.O_DONE !== 1'b0) begin
         errors++;
         $display("FAIL modes_done_pulse: done=%b want 0", bus.O_DONE);
      end
   endtask

   // Six gray pixels 11..66, downstream stalls on cycles 3..6.
   task automatic test_backpressure;
      logic [23:0] got[$];
      logic [23:0] held;
      logic [7:0]  v;
      logic        prev_stall;
      int          idx;
      idx = 0;
      prev_stall = 1'b0;
      held = '0;
      for (int c = 0; c < 40 && got.size() < 6; c++) begin
         v = 8'(11 * (idx + 1));
         bus.I_READY = !(c >= 3 && c < 7);
         if (idx < 6) drive(1'b1, 2'd0, v, v, v, idx == 5);
         else drive(1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
         #1;
         if (!bus.I_READY) begin
            checks++;
            if (bus.O_READY !== 1'b0) begin
               errors++;
               $display("FAIL bp_ready c=%0d: got %b want 0", c, bus.O_READY);
            end
            if (prev_stall) begin
               checks++;
               if (bus.O_VALID !== 1'b1 || bus.O_PIXEL !== held) begin
                  errors++;
                  $display("FAIL bp_hold c=%0d: valid=%b pixel=%h want 1/%h", c, bus.O_VALID, bus.O_PIXEL, held);
               end
            end
            held = bus.O_PIXEL;
         end
         prev_stall = !bus.I_READY;
         if (bus.O_VALID && bus.I_READY) got.push_back(bus.O_PIXEL);
         if (bus.I_VALID && bus.O_READY) idx++;
         tick;
      end
      bus.I_READY = 1'b1;
      drive(1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      checks++;
      if (got.size() != 6) begin
         errors++;
         $display("FAIL bp_count: received %0d pixels want 6", got.size());
      end
      for (int i = 0; i < got.size() && i < 6; i++) begin
         v = 8'(11 * (i + 1));
         checks++;
         if (got[i] !== {v, v, v}) begin
            errors++;
            $display("FAIL bp_order %0d: got %h want %h", i, got[i], {v, v, v});
         end
      end
      checks++;
      if (bus.O_COUNT !== 20'd0 || bus.O_DONE !== 1'b1) begin
         errors++;
         $display("FAIL bp_frame_end: count=%0d done=%b want 0/1", bus.O_COUNT, bus.O_DONE);
      end
      tick;
      checks++;
      if (bus.O_VALID !== 1'b0) begin
         errors++;
         $display("FAIL bp_extra: valid=%b want 0", bus.O_VALID);
      end
   endtask

   // Five-pixel frame then the first pixel of the next one.
   task automatic test_frame;
      logic [7:0] v;
      int n;
      for (int t = 0; t < 9; t++) begin
         v = 8'(10 * (t + 1));
         if (t < 6) drive(1'b1, 2'd0, v, v, v, t == 4);
         else drive(1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
         tick;
         if (t >= 2) begin
            n = t - 2;
            checks++;
            if (bus.O_COUNT !== 20'(n <= 4 ? n : n - 5) || bus.O_DONE !== (n == 5)) begin
               errors++;
               $display("FAIL frame_count n=%0d: count=%0d done=%b want %0d/%b", n, bus.O_COUNT, bus.O_DONE,
                        n <= 4 ? n : n - 5, n == 5);
            end
         end
      end
   endtask

   // Two pixels in flight when enable drops for three cycles; count starts at 1.
   task automatic test_enable;
      int ev[3] = '{1, 1, 0};
      int ep[3] = '{40, 80, 0};
      int ec[3] = '{1, 2, 3};
      logic [7:0] p;
      drive(1'b1, 2'd0, 8'd40, 8'd40, 8'd40, 1'b0);
      tick;
      drive(1'b1, 2'd0, 8'd80, 8'd80, 8'd80, 1'b0);
      tick;
      bus.I_ENABLE = 1'b0;
      drive(1'b1, 2'd0, 8'd120, 8'd120, 8'd120, 1'b1);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (bus.O_READY !== 1'b0) begin
            errors++;
            $display("FAIL en_ready k=%0d: got %b want 0", k, bus.O_READY);
         end
         tick;
         p = 8'(ep[k]);
         checks++;
         if (bus.O_VALID !== 1'(ev[k]) || (ev[k] == 1 && bus.O_PIXEL !== {p, p, p}) || bus.O_COUNT !== 20'(ec[k])) begin
            errors++;
            $display("FAIL en_drain k=%0d: valid=%b pixel=%h count=%0d want %0d/%h/%0d", k, bus.O_VALID,
                     bus.O_PIXEL, bus.O_COUNT, ev[k], {p, p, p}, ec[k]);
         end
      end
      bus.I_ENABLE = 1'b1;
      #1;
      checks++;
      if (bus.O_READY !== 1'b1) begin
         errors++;
         $display("FAIL en_resume: ready=%b want 1", bus.O_READY);
      end
      tick;
      drive(1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      tick;
      tick;
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O_PIXEL !== 24'h787878 || bus.O_COUNT !== 20'd3) begin
         errors++;
         $display("FAIL en_after: valid=%b pixel=%h count=%0d want 1/787878/3", bus.O_VALID, bus.O_PIXEL, bus.O_COUNT);
      end
      tick;
      checks++;
      if (bus.O_VALID !== 1'b0 || bus.O_COUNT !== 20'd0 || bus.O_DONE !== 1'b1) begin
         errors++;
         $display("FAIL en_frame_end: valid=%b count=%0d done=%b want 0/0/1", bus.O_VALID, bus.O_COUNT, bus.O_DONE);
      end
   endtask

   // Reset mid-cycle with three pixels in flight and two already out.
   task automatic test_async_reset;
      logic [7:0] v;
      for (int t = 0; t < 5; t++) begin
         v = 8'(16 * (t + 1));
         drive(1'b1, 2'd0, v, v, v, 1'b0);
         tick;
      end
      drive(1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O_COUNT !== 20'd2) begin
         errors++;
         $display("FAIL ar_pre: valid=%b count=%0d want 1/2", bus.O_VALID, bus.O_COUNT);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.O_VALID !== 1'b0 || bus.O_COUNT !== 20'd0 || bus.O_DONE !== 1'b0 || bus.O_PIXEL !== 24'h0) begin
         errors++;
         $display("FAIL ar_immediate: valid=%b count=%0d done=%b pixel=%h want 0/0/0/000000", bus.O_VALID,
                  bus.O_COUNT, bus.O_DONE, bus.O_PIXEL);
      end
      checks++;
      if (bus.O_READY !== 1'b0) begin
         errors++;
         $display("FAIL ar_ready: got %b want 0", bus.O_READY);
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int t = 0; t < 5; t++) begin
         tick;
         checks++;
         if (bus.O_VALID !== 1'b0 || bus.O_COUNT !== 20'd0) begin
            errors++;
            $display("FAIL ar_stale t=%0d: valid=%b count=%0d want 0/0", t, bus.O_VALID, bus.O_COUNT);
         end
      end
   endtask

   initial begin
      test_reset;
      test_modes;
      test_backpressure;
      test_frame;
      test_enable;
      test_async_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/grayscale_pipe.md
Name: grayscale_pipe

Overview:
Parametrised, pipelined successor to the single-mode grayscale converter. It converts a packed RGB pixel stream to luma using a per-pixel selectable mode (Rec.601, Rec.709, channel average, channel max), with valid/ready flow control and frame-end signalling. It sits between the pixel input stage and the edge-detection filter stages. Output luma is replicated into all three channels so downstream blocks keep the RGB pixel width.

Parameters:
P_CHANNEL_DEPTH, 8, bits per colour channel (min 4); pixel width = 3*P_CHANNEL_DEPTH
P_COUNT_WIDTH, 20, width of output pixel counter

Ports:
I_CLK  input  1  clock, rising edge
I_RESET  input  1  asynchronous active-high reset
I_ENABLE  input  1  when low, no new pixels accepted; pipeline contents still drain
I_MODE  input  2  00 Rec.601, 01 Rec.709, 10 average, 11 max; sampled with each accepted pixel
I_PIXEL  input  3*P_CHANNEL_DEPTH  R=[3C-1:2C], G=[2C-1:C], B=[C-1:0]
I_LAST  input  1  marks final pixel of a frame; sampled with pixel
I_VALID  input  1  input pixel valid
O_READY  output  1  converter can accept a pixel this cycle
O_PIXEL  output  3*P_CHANNEL_DEPTH  luma Y replicated {Y,Y,Y}
O_VALID  output  1  O_PIXEL valid
I_READY  input  1  downstream accepts O_PIXEL
O_COUNT  output  P_COUNT_WIDTH  pixels transferred out in current frame
O_DONE  output  1  one-cycle pulse when the last pixel of a frame transfers out

Behaviour:
- Reset is asynchronous, active-high, with one clock; all stage valids cleared, O_PIXEL=0, O_VALID=0, O_COUNT=0, O_DONE=0. O_READY is 0 during reset.
- Pipeline has 3 registered stages; mode and last travel with data.
  - S1: multiply each channel by 8-bit fractional coefficients; products are C+8 bits. For max mode, register max(R,G,B).
  - S2: sum the three products (C+10 bits). Max mode bypasses the sum.
  - S3: add 128, shift right 8, saturate to 2^C-1, replicate to O_PIXEL.
- Coefficients (R,G,B), /256:
  - 601: 77,150,29
  - 709: 54,183,19
  - average: 85,86,85
  - max: Y = max(R,G,B) exactly.
- Latency: an accepted pixel appears on O_PIXEL/O_VALID 3 cycles after acceptance when there is no stall.
- Flow control:
  - advance = !S3_valid || I_READY; all stages shift together when advance=1 and hold when advance=0. No bubble collapse is required.
  - O_READY = I_ENABLE && advance && !I_RESET.
  - Input transfer = I_VALID && O_READY; output transfer = O_VALID && I_READY.
  - On advance with no input transfer, a bubble (valid=0) enters S1.
  - O_PIXEL and O_VALID stay stable while O_VALID=1 and I_READY=0.
- I_ENABLE low mid-frame: intake stops, held pixels drain normally, and frame state is preserved.
- Counter:
  - O_COUNT increments on each output transfer and wraps modulo 2^P_COUNT_WIDTH.
  - On a transfer with last=1, O_COUNT goes to 0 and O_DONE=1 for exactly that next cycle.
- Simultaneous input and output transfer in the same cycle is legal and sustains a throughput of 1 pixel/clock.
- Reset asserted mid-frame: in-flight pixels are discarded and the counter is cleared immediately (asynchronous).

Test Plan:
- Mode 601, C=8, stream (255,0,0),(255,255,255),(100,100,100), I_READY=1 -> O_PIXEL Y=77, 255, 100 on cycles 3,4,5 after first accept; O_VALID continuous.
- Mode 709 (0,255,0) -> Y=182 (0xB6B6B6); mode average (30,60,90) -> Y=60; mode max (30,60,90) -> Y=90; interleave modes per pixel, each result correct.
- Backpressure: stream 6 pixels, I_READY low for 4 cycles mid-stream -> O_READY low during stall, no pixel lost or duplicated, O_PIXEL stable while stalled, order preserved.
- Frame end: 5-pixel frame with I_LAST on pixel 5 -> O_COUNT steps 1..4, then 0, with a single O_DONE pulse on the cycle after pixel 5 transfers. The next frame starts counting from 1.
- I_ENABLE dropped for 3 cycles with 2 pixels in flight -> both pixels emerge, O_READY=0 throughout, and intake resumes when enable returns.
- Async reset pulse with 3 pixels in flight and O_COUNT=2 -> O_VALID, O_COUNT and O_DONE go to 0 without a clock edge; no stale pixel emerges after release.
